regfile: RTL

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_read_port.sv | 37 +++
 rtl/regfile.sv | 68 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file definitions
// Provides enable levels, bus widths, register count and the zero-register
// index used by regfile and regfile_read_port.
package regfile_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int REGS_ADDR_BUS = 5;
  localparam int REGS_DATA_BUS = 32;
  localparam int REG_NUM       = 32;

  localparam logic [REGS_ADDR_BUS-1:0] ZERO_REG = '0;

  typedef logic [REGS_ADDR_BUS-1:0] reg_addr_t;
  typedef logic [REGS_DATA_BUS-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port with write-back bypass
// Ports:
//   reset        : forces the output to zero while asserted
//   read_enable  : read request; output is zero when deasserted
//   read_addr    : source register index
//   reg_data     : stored value of register[read_addr], selected by the parent
//   write_enable : write-back request in the current cycle
//   write_addr   : write-back destination index
//   write_data   : write-back value, forwarded on an address match
//   read_data    : operand presented to the ID stage
module regfile_read_port
  import regfile_pkg::*;
(
  input  logic                     reset,
  input  logic                     read_enable,
  input  logic [REGS_ADDR_BUS-1:0] read_addr,
  input  logic [REGS_DATA_BUS-1:0] reg_data,
  input  logic                     write_enable,
  input  logic [REGS_ADDR_BUS-1:0] write_addr,
  input  logic [REGS_DATA_BUS-1:0] write_data,
  output logic [REGS_DATA_BUS-1:0] read_data
);

  always_comb begin
    read_data = '0;
    if (reset == ENABLE || read_enable == DISABLE || read_addr == ZERO_REG) begin
      read_data = '0;
    end else if (write_enable == ENABLE && write_addr == read_addr) begin
      // Forward the value being written this cycle so the reader never sees
      // the stale copy (write-before-read).
      read_data = write_data;
    end else begin
      read_data = reg_data;
    end
  end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32 x 32 register file, two bypassed read ports, write counter
// Ports:
//   clock        : rising-edge clock for all state
//   reset        : synchronous, active-high; clears registers and write_count
//   write_enable : write-back request
//   write_addr   : destination index (writes to index 0 are dropped)
//   write_data   : value to write
//   read1_enable, read1_addr, read1_data : read port 1
//   read2_enable, read2_addr, read2_data : read port 2
//   write_count  : committed writes since reset, wraps modulo 2^32
module regfile
  import regfile_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [REGS_ADDR_BUS-1:0] write_addr,
  input  logic [REGS_DATA_BUS-1:0] write_data,
  input  logic                     read1_enable,
  input  logic [REGS_ADDR_BUS-1:0] read1_addr,
  output logic [REGS_DATA_BUS-1:0] read1_data,
  input  logic                     read2_enable,
  input  logic [REGS_ADDR_BUS-1:0] read2_addr,
  output logic [REGS_DATA_BUS-1:0] read2_data,
  output logic [REGS_DATA_BUS-1:0] write_count
);

  logic [REGS_DATA_BUS-1:0] regs [REG_NUM];
  logic                     write_commit;

  assign write_commit = (write_enable == ENABLE) && (write_addr != ZERO_REG);

  // Register 0 is never written, so it holds the zero from reset forever.
  always_ff @(posedge clock) begin
    if (reset == ENABLE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
      write_count <= '0;
    end else if (write_commit) begin
      regs[write_addr] <= write_data;
      write_count      <= write_count + REGS_DATA_BUS'(1);
    end
  end

  regfile_read_port u_read1 (
    .reset        (reset),
    .read_enable  (read1_enable),
    .read_addr    (read1_addr),
    .reg_data     (regs[read1_addr]),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_data    (read1_data)
  );

  regfile_read_port u_read2 (
    .reset        (reset),
    .read_enable  (read2_enable),
    .read_addr    (read2_addr),
    .reg_data     (regs[read2_addr]),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_data    (read2_data)
  );

endmodule
